serial_add_ctrl: RTL and testbench

Bit-serial adder sequencer. It time-multiplexes one full-adder cell (s = a^b^c, c = ab | c(a^b)) over WIDTH cycles to add two WIDTH-bit operands.
- Owns the operand/result shift registers, the carry flip-flop, the bit counter and the valid/ready handshakes on both sides.
- Used wherever area matters more than latency, in place of a WIDTH-wide ripple adder.

---
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_add_ctrl.sv | 102 ++++++++++
 tb/tb_serial_add_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl; adds the sub operand when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, result valid WIDTH cycles after accept.
// Define SERIAL_ADD_SUB_EN to add a latched sub operand that computes a-b (cout=1 means no borrow).
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sha_q, shb_q, res_q, sum_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, in_ready_q, out_valid_q;
  logic             b_bit, s_bit, c_d, carry_init;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q;
  // Subtraction is a + ~b + 1, so the cell sees the inverted b bit and a forced carry-in.
  assign b_bit      = shb_q[0] ^ sub_q;
  assign carry_init = bus.sub | bus.cin;
`else
  assign b_bit      = shb_q[0];
  assign carry_init = bus.cin;
`endif

  always_comb begin
    s_bit = sha_q[0] ^ b_bit ^ carry_q;
    c_d   = (sha_q[0] & b_bit) | (carry_q & (sha_q[0] ^ b_bit));
    res_d = res_q >> 1;
    res_d[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sha_q       <= '0;
      shb_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sha_q      <= bus.a;
            shb_q      <= bus.b;
            carry_q    <= carry_init;
            cnt_q      <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q      <= bus.sub;
`endif
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sha_q   <= sha_q >> 1;
          shb_q   <= shb_q >> 1;
          carry_q <= c_d;
          res_q   <= res_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q       <= res_d;
            cout_q      <= c_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Only the output handshake completes here; in_valid is ignored until IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, directed vectors, queued expected results.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_pass = 0;
  int n_total = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitors: one pop per completed output handshake, expected value is {cout, sum}.
  always @(negedge clk) begin
    if (rst_n && bus8.out_valid === 1'b1 && bus8.out_ready === 1'b1) begin
      if (q8.size() == 0) check("result8_unexpected", 32'(q8.size()), 32'd1);
      else check("result8", 32'({bus8.cout, bus8.sum}), 32'(q8.pop_front()));
    end
    if (rst_n && bus1.out_valid === 1'b1 && bus1.out_ready === 1'b1) begin
      if (q1.size() == 0) check("result1_unexpected", 32'(q1.size()), 32'd1);
      else check("result1", 32'({bus1.cout, bus1.sum}), 32'(q1.pop_front()));
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                     input logic [7:0] es, input logic ec, input string tag);
    int   k;
    logic busy_ok;
    k = 0;
    while (bus8.in_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    check({tag, "_idle"}, 32'(bus8.in_ready), 32'd1);
    bus8.a = a; bus8.b = b; bus8.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = sub;
`else
    if (sub) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = 'x; bus8.b = 'x; bus8.cin = 'x;
    q8.push_back({ec, es});
    busy_ok = 1'b1;
    k = 0;
    while (bus8.out_valid !== 1'b1 && k < 20) begin
      if (bus8.in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1; k++;
    end
    if (bus8.in_ready !== 1'b0) busy_ok = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'd8);
    check({tag, "_in_ready_busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic op1(input logic a, input logic b, input logic cin, input logic [1:0] exp, input string tag);
    int k;
    k = 0;
    while (bus1.in_ready !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    q1.push_back(exp);
    k = 0;
    while (bus1.out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    check({tag, "_latency"}, 32'(k), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = 1'b0; bus1.sub = 1'b0;
`endif
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    check("rst_sum", 32'(bus8.sum), 32'd0);
    check("rst_cout", 32'(bus8.cout), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, "add_5a_33");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01");
    op8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "add_ff_00_c");
    op8(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, "add_00_00_c");
    op8(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, "add_80_80_c");
    op8(8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, "add_a5_5a");

    // Backpressure: result must hold while new operands are offered and refused.
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      bus8.a = 8'h77; bus8.b = 8'h11; bus8.cin = 1'b0;
      bus8.in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_hold", 32'({bus8.out_valid, bus8.in_ready, bus8.sum}), 32'({1'b1, 1'b0, 8'h46}));
    end
    bus8.in_valid = 1'b1;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'({bus8.in_ready, bus8.out_valid}), 32'd2);
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_no_accept", 32'(bus8.in_ready), 32'd1);
    check("sum_hold_idle", 32'({bus8.cout, bus8.sum}), 32'h046);

    // Abort mid-RUN: outputs clear at once and nothing reaches the scoreboard.
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus8.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus8.out_valid), 32'd0);
    check("abort_sum_cout", 32'({bus8.cout, bus8.sum}), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, "after_abort");

`ifdef SERIAL_ADD_SUB_EN
    op8(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, "sub_10_01");
    op8(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, "sub_01_02");
    op8(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, "sub0_5a_33");
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "sub0_ff_01");
`endif

    op1(1'b1, 1'b1, 1'b1, 2'b11, "w1_111");
    op1(1'b1, 1'b0, 1'b0, 2'b01, "w1_100");
    op1(1'b0, 1'b1, 1'b1, 2'b10, "w1_011");

    repeat (3) @(posedge clk); #1;
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
